// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - wormhole round-robin arbiter sharing one output link between E/S/W/L input FIFOs
// A packet locks the grant from its head flit until its tail (or single) flit transfers downstream.
module noc_output_arbiter #(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
) (
  input  logic                fifo_clk,
  input  logic                rst_n,

  input  logic                E_valid_in,
  input  logic                S_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,

  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,

  input  logic                E_req_in,
  input  logic                S_req_in,
  input  logic                W_req_in,
  input  logic                L_req_in,

  input  logic [WIDTH:0]      E_pressure_in,
  input  logic [WIDTH:0]      S_pressure_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,

  output logic                fifo_ready_E,
  output logic                fifo_ready_S,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,

  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_full_in,

  output logic [3:0]          grant_out,
  output logic [WIDTH:0]      pressure_sel,
  output logic                busy,
  output logic                proto_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [3:0]          grant;
  logic [1:0]          g_idx;
  logic [1:0]          rr_ptr;
  logic                first_flit;

  logic [3:0]          valid_v;
  logic [3:0]          route_v;
  logic [3:0]          starts_v;
  logic [3:0]          req_v;
  logic [3:0]          bad_req_v;
  logic [DATASIZE-1:0] data_a  [4];
  logic [WIDTH:0]      press_a [4];

  assign valid_v = {L_valid_in, W_valid_in, S_valid_in, E_valid_in};
  assign route_v = {L_req_in, W_req_in, S_req_in, E_req_in};

  assign data_a[0] = E_data_in;
  assign data_a[1] = S_data_in;
  assign data_a[2] = W_data_in;
  assign data_a[3] = L_data_in;

  assign press_a[0] = E_pressure_in;
  assign press_a[1] = S_pressure_in;
  assign press_a[2] = W_pressure_in;
  assign press_a[3] = L_pressure_in;

  // Type bit DATASIZE-2 is set exactly for HEAD (01) and SINGLE (11): the packet-opening flits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      starts_v[i] = data_a[i][DATASIZE-2];
    end
  end

  assign req_v     = valid_v & route_v & starts_v;
  assign bad_req_v = valid_v & route_v & ~starts_v;

  logic       any_req;
  logic [1:0] pick;
  logic [1:0] scan_idx;
  logic       found;

  always_comb begin
    pick     = rr_ptr;
    scan_idx = rr_ptr;
    found    = 1'b0;
    any_req  = |req_v;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!found && req_v[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  logic                locked;
  logic                g_valid;
  logic [DATASIZE-1:0] g_data;
  logic                g_starts;
  logic                g_ends;
  logic                pop;

  assign locked   = (state == LOCKED);
  assign g_valid  = valid_v[g_idx];
  assign g_data   = data_a[g_idx];
  assign g_starts = g_data[DATASIZE-2];
  // TAIL (10) and SINGLE (11) both close the packet.
  assign g_ends   = g_data[DATASIZE-1];
  assign pop      = locked & g_valid & ~out_full_in;

  assign out_valid    = locked & g_valid;
  assign out_data     = locked ? g_data : '0;
  assign pressure_sel = locked ? press_a[g_idx] : '0;

  assign fifo_ready_E = pop & grant[0];
  assign fifo_ready_S = pop & grant[1];
  assign fifo_ready_W = pop & grant[2];
  assign fifo_ready_L = pop & grant[3];

  assign grant_out = grant;

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      g_idx      <= 2'd0;
      rr_ptr     <= 2'd0;
      first_flit <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bad_req_v) begin
            proto_err <= 1'b1;
          end
          if (any_req) begin
            state      <= LOCKED;
            grant      <= 4'b0001 << pick;
            g_idx      <= pick;
            first_flit <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOCKED: begin
          // A packet-opening flit after the first one means the source lost a tail.
          if (g_valid && !first_flit && g_starts) begin
            proto_err <= 1'b1;
          end
          if (pop) begin
            first_flit <= 1'b0;
          end
          if (pop && g_ends) begin
            state  <= IDLE;
            grant  <= 4'b0000;
            busy   <= 1'b0;
            rr_ptr <= g_idx + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed scoreboard bench for noc_output_arbiter
// Bench-side FIFO models feed the arbiter; expected flits are queued in predicted order.
module tb_noc_output_arbiter;

  localparam int DS = 40;
  localparam int WD = 3;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic fifo_clk, rst_n;
  logic E_valid_in, S_valid_in, W_valid_in, L_valid_in;
  logic [DS-1:0] E_data_in, S_data_in, W_data_in, L_data_in;
  logic E_req_in, S_req_in, W_req_in, L_req_in;
  logic [WD:0] E_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in;
  logic fifo_ready_E, fifo_ready_S, fifo_ready_W, fifo_ready_L;
  logic [DS-1:0] out_data;
  logic out_valid, out_full_in, busy, proto_err;
  logic [3:0] grant_out;
  logic [WD:0] pressure_sel;

  noc_output_arbiter #(.DATASIZE(DS), .WIDTH(WD)) dut (
    .fifo_clk(fifo_clk), .rst_n(rst_n),
    .E_valid_in(E_valid_in), .S_valid_in(S_valid_in), .W_valid_in(W_valid_in), .L_valid_in(L_valid_in),
    .E_data_in(E_data_in), .S_data_in(S_data_in), .W_data_in(W_data_in), .L_data_in(L_data_in),
    .E_req_in(E_req_in), .S_req_in(S_req_in), .W_req_in(W_req_in), .L_req_in(L_req_in),
    .E_pressure_in(E_pressure_in), .S_pressure_in(S_pressure_in),
    .W_pressure_in(W_pressure_in), .L_pressure_in(L_pressure_in),
    .fifo_ready_E(fifo_ready_E), .fifo_ready_S(fifo_ready_S),
    .fifo_ready_W(fifo_ready_W), .fifo_ready_L(fifo_ready_L),
    .out_data(out_data), .out_valid(out_valid), .out_full_in(out_full_in),
    .grant_out(grant_out), .pressure_sel(pressure_sel), .busy(busy), .proto_err(proto_err)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DS-1:0] mem [4][64];
  int rd [4];
  int wr [4];
  logic [DS-1:0] sb [$];

  function automatic logic [DS-1:0] mk(logic [1:0] t, int p);
    return {t, 38'(p)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    logic [3:0]    v;
    logic [DS-1:0] d [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = (rd[i] != wr[i]);
      d[i] = v[i] ? mem[i][rd[i]] : '0;
    end
    E_valid_in = v[0]; S_valid_in = v[1]; W_valid_in = v[2]; L_valid_in = v[3];
    E_data_in = d[0]; S_data_in = d[1]; W_data_in = d[2]; L_data_in = d[3];
    E_pressure_in = (WD+1)'(wr[0] - rd[0]);
    S_pressure_in = (WD+1)'(wr[1] - rd[1]);
    W_pressure_in = (WD+1)'(wr[2] - rd[2]);
    L_pressure_in = (WD+1)'(wr[3] - rd[3]);
  endtask

  task automatic push(int src, logic [DS-1:0] f, bit expect_out);
    mem[src][wr[src]] = f;
    wr[src]++;
    if (expect_out) sb.push_back(f);
    refresh();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    sb.delete();
    refresh();
  endtask

  // One clock: check the transfer about to happen, then pop the FIFO the DUT strobed.
  task automatic tick();
    logic [3:0]    rdy;
    logic [DS-1:0] exp_flit;
    #1;
    rdy = {fifo_ready_L, fifo_ready_W, fifo_ready_S, fifo_ready_E};
    chk("ready_at_most_one", 64'($countones(rdy) <= 1), 64'(1));
    chk("ready_matches_xfer", 64'(rdy), 64'((out_valid && !out_full_in) ? grant_out : 4'b0000));
    if (out_valid && !out_full_in) begin
      exp_flit = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("out_data", 64'(out_data), 64'(exp_flit));
    end
    @(posedge fifo_clk);
    #1;
    for (int i = 0; i < 4; i++) if (rdy[i]) rd[i]++;
    refresh();
    @(negedge fifo_clk);
  endtask

  task automatic set_req(logic [3:0] r);
    {L_req_in, W_req_in, S_req_in, E_req_in} = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    set_req(4'b0000);
    out_full_in = 1'b0;
    @(negedge fifo_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_full_in = 1'b0;
    set_req(4'b0000);
    clear_all();
    #1;
    chk("rst_grant", 64'(grant_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_proto", 64'(proto_err), 64'(0));
    chk("rst_pressure", 64'(pressure_sel), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    @(negedge fifo_clk);
    @(negedge fifo_clk);
    rst_n = 1'b1;

    // Single flit on E.
    push(0, mk(T_SINGLE, 'hAA), 1);
    set_req(4'b0001);
    #1;
    chk("t1_idle_grant", 64'(grant_out), 64'(0));
    chk("t1_idle_ready", 64'(fifo_ready_E), 64'(0));
    chk("t1_idle_valid", 64'(out_valid), 64'(0));
    tick();
    chk("t1_grant", 64'(grant_out), 64'(4'b0001));
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_ready_E", 64'(fifo_ready_E), 64'(1));
    tick();
    chk("t1_back_idle", 64'(busy), 64'(0));
    chk("t1_grant_clear", 64'(grant_out), 64'(0));

    // rr_ptr is now 1: S beats E.
    push(0, mk(T_SINGLE, 'hBB), 0);
    push(1, mk(T_SINGLE, 'hCC), 0);
    sb.push_back(mk(T_SINGLE, 'hCC));
    sb.push_back(mk(T_SINGLE, 'hBB));
    set_req(4'b0011);
    tick();
    chk("rr1_grant_S", 64'(grant_out), 64'(4'b0010));
    tick();
    tick();
    chk("rr1_grant_E", 64'(grant_out), 64'(4'b0001));
    tick();
    chk("rr1_sb_empty", 64'(sb.size()), 64'(0));

    // Four 3-flit packets from rr_ptr = 0.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      push(s, mk(T_HEAD, 'h100 + s), 0);
      push(s, mk(T_BODY, 'h200 + s), 0);
      push(s, mk(T_TAIL, 'h300 + s), 0);
    end
    for (int s = 0; s < 4; s++) begin
      sb.push_back(mk(T_HEAD, 'h100 + s));
      sb.push_back(mk(T_BODY, 'h200 + s));
      sb.push_back(mk(T_TAIL, 'h300 + s));
    end
    set_req(4'b1111);
    #1;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] eg;
      eg = (c % 4 == 0) ? 4'b0000 : (4'b0001 << (c / 4));
      chk($sformatf("t2_grant_c%0d", c), 64'(grant_out), 64'(eg));
      chk($sformatf("t2_busy_c%0d", c), 64'(busy), 64'(eg != 0));
      if (c == 1) chk("t2_pressure_E", 64'(pressure_sel), 64'(3));
      tick();
    end
    chk("t2_final_idle", 64'(grant_out), 64'(0));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));
    set_req(4'b0000);

    // Downstream stall on S mid-packet.
    push(1, mk(T_HEAD, 'h510), 1);
    push(1, mk(T_BODY, 'h511), 1);
    push(1, mk(T_TAIL, 'h512), 1);
    set_req(4'b0010);
    tick();
    tick();
    out_full_in = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t3_stall_ready", 64'(fifo_ready_S), 64'(0));
      chk("t3_stall_valid", 64'(out_valid), 64'(1));
      chk("t3_stall_data", 64'(out_data), 64'(mk(T_BODY, 'h511)));
      chk("t3_stall_grant", 64'(grant_out), 64'(4'b0010));
      tick();
    end
    out_full_in = 1'b0;
    #1;
    chk("t3_resume_ready", 64'(fifo_ready_S), 64'(1));
    tick();
    tick();
    chk("t3_done", 64'(busy), 64'(0));
    set_req(4'b0000);

    // Bubble on W while E waits; rr_ptr is 2 so W wins.
    push(2, mk(T_HEAD, 'h600), 1);
    push(0, mk(T_SINGLE, 'h6EE), 0);
    set_req(4'b0101);
    tick();
    chk("t4_grant_W", 64'(grant_out), 64'(4'b0100));
    tick();
    for (int c = 0; c < 2; c++) begin
      chk("t4_bubble_grant", 64'(grant_out), 64'(4'b0100));
      chk("t4_bubble_valid", 64'(out_valid), 64'(0));
      chk("t4_bubble_E_ready", 64'(fifo_ready_E), 64'(0));
      tick();
    end
    push(2, mk(T_TAIL, 'h601), 1);
    sb.push_back(mk(T_SINGLE, 'h6EE));
    tick();
    chk("t4_rearb_idle", 64'(grant_out), 64'(0));
    tick();
    chk("t4_grant_E", 64'(grant_out), 64'(4'b0001));
    tick();
    chk("t4_done", 64'(busy), 64'(0));
    chk("t4_no_proto", 64'(proto_err), 64'(0));
    chk("t4_sb_empty", 64'(sb.size()), 64'(0));
    set_req(4'b0000);

    // BODY flit requesting while IDLE.
    push(3, mk(T_BODY, 'h700), 0);
    set_req(4'b1000);
    tick();
    chk("t5_no_grant", 64'(grant_out), 64'(0));
    chk("t5_proto_set", 64'(proto_err), 64'(1));
    rd[3] = wr[3];
    refresh();
    set_req(4'b0000);
    tick();
    chk("t5_proto_sticky", 64'(proto_err), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_proto_cleared", 64'(proto_err), 64'(0));
    @(negedge fifo_clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-packet on E.
    push(0, mk(T_HEAD, 'h800), 1);
    push(0, mk(T_BODY, 'h801), 0);
    push(0, mk(T_TAIL, 'h802), 0);
    set_req(4'b0001);
    tick();
    tick();
    chk("t6_locked", 64'(grant_out), 64'(4'b0001));
    rst_n = 1'b0;
    #1;
    chk("t6_grant_drop", 64'(grant_out), 64'(0));
    chk("t6_busy_drop", 64'(busy), 64'(0));
    chk("t6_ready_drop", 64'(fifo_ready_E), 64'(0));
    chk("t6_valid_drop", 64'(out_valid), 64'(0));
    clear_all();
    set_req(4'b0000);
    @(negedge fifo_clk);
    rst_n = 1'b1;
    push(1, mk(T_SINGLE, 'h901), 0);
    push(0, mk(T_SINGLE, 'h900), 0);
    sb.push_back(mk(T_SINGLE, 'h900));
    sb.push_back(mk(T_SINGLE, 'h901));
    set_req(4'b0011);
    tick();
    chk("t6_rr_reset_E", 64'(grant_out), 64'(4'b0001));
    tick();
    tick();
    chk("t6_then_S", 64'(grant_out), 64'(4'b0010));
    tick();
    set_req(4'b0000);
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
